// File: rtl/floo_wormhole_output_arbiter_if.sv
// Handshake/bus bundle between NumInp upstream inputs, the output arbiter and the downstream link.
// The master side drives input flits and downstream ready; the slave side is the arbiter itself.
interface floo_wormhole_output_arbiter_if #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 64,
    parameter int IdxWidth  = $clog2(NumInp)
);
    logic [NumInp-1:0]           valid_i;
    logic [NumInp-1:0]           ready_o;
    logic [NumInp*DataWidth-1:0] data_i;
    logic [NumInp-1:0]           last_i;
    logic                        valid_o;
    logic                        ready_i;
    logic [DataWidth-1:0]        data_o;
    logic                        last_o;
    logic                        locked_o;
    logic [IdxWidth-1:0]         grant_idx_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, last_o, locked_o, grant_idx_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, last_o, locked_o, grant_idx_o
    );
endinterface

// File: rtl/floo_wormhole_output_arbiter.sv
// Round-robin, wormhole-locked arbiter sharing one registered output link among NumInp inputs.
// A multi-flit packet keeps the port until its last flit is accepted.
module floo_wormhole_output_arbiter #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 64,
    parameter int IdxWidth  = $clog2(NumInp)
) (
    input logic clk_i,
    input logic rst_i,
    floo_wormhole_output_arbiter_if.slave bus
);

    typedef enum logic [0:0] {IDLE, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [IdxWidth-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]  owner_q, owner_d;
    logic [IdxWidth-1:0]  grant_q, grant_d;
    logic [IdxWidth-1:0]  sel, idx, cur;
    logic                 found, can_accept, hs;
    logic [NumInp-1:0]    ready_vec;
    logic [DataWidth-1:0] cur_data;
    logic                 valid_q, last_q;
    logic [DataWidth-1:0] data_q;

    function automatic logic [IdxWidth-1:0] inc_wrap(input logic [IdxWidth-1:0] i);
        if (i == IdxWidth'(NumInp - 1)) return '0;
        return i + 1'b1;
    endfunction

    // Round-robin search: first valid input at or after rr_ptr, wrapping.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int i = 0; i < NumInp; i++) begin
            if (!found && bus.valid_i[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = inc_wrap(idx);
        end
    end

    // While locked only the owner may be served, even if it is currently bubbling.
    always_comb begin
        can_accept = !valid_q || bus.ready_i;
        cur        = (state_q == LOCKED) ? owner_q : sel;
        ready_vec  = '0;
        if (!rst_i && (state_q == LOCKED || found)) ready_vec[cur] = can_accept;
        hs         = bus.valid_i[cur] && ready_vec[cur];
        cur_data   = bus.data_i[int'(cur)*DataWidth +: DataWidth];

        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        if (hs) begin
            if (state_q == IDLE) begin
                grant_d = cur;
                if (bus.last_i[cur]) begin
                    rr_ptr_d = inc_wrap(cur);
                end else begin
                    state_d = LOCKED;
                    owner_d = cur;
                end
            end else if (bus.last_i[cur]) begin
                state_d  = IDLE;
                rr_ptr_d = inc_wrap(cur);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
        end
    end

    // One-entry output register: a new flit may load in the same cycle the old one drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (hs) begin
            valid_q <= 1'b1;
            data_q  <= cur_data;
            last_q  <= bus.last_i[cur];
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ready_o     = ready_vec;
    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.last_o      = last_q;
    assign bus.locked_o    = (state_q == LOCKED);
    assign bus.grant_idx_o = grant_q;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ready_vec));

    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_q && !bus.ready_i) |=> ($stable(data_q) && $stable(last_q)));

    a_owner_only: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == LOCKED) |-> ((bus.valid_i & ready_vec & ~(NumInp'(1) << owner_q)) == '0));

endmodule

// File: doc/floo_wormhole_output_arbiter.md
Name: floo_wormhole_output_arbiter

Overview:
- Per-output-port arbiter for a FlooNoC router link.
- Shares one output channel between NumInp input ports.
- Round-robin grant, wormhole-locked: once a multi-flit packet starts, its input holds the port until its last flit is accepted.
- Drives the output through a one-entry register stage, so the link is registered and runs at full throughput.

Parameters:
- NumInp, 4, number of competing input ports (>=2).
- DataWidth, 64, flit payload width excluding the last bit.
- IdxWidth, $clog2(NumInp), width of the grant index (derived; do not override).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- valid_i  input  NumInp  per-input flit valid.
- ready_o  output  NumInp  per-input flit accept.
- data_i  input  NumInp*DataWidth  per-input flit payload, packed, input 0 at LSBs.
- last_i  input  NumInp  per-input last-flit-of-packet marker.
- valid_o  output  1  output flit valid (registered).
- ready_i  input  1  downstream accept.
- data_o  output  DataWidth  output payload (registered).
- last_o  output  1  output last marker (registered).
- locked_o  output  1  high while in LOCKED.
- grant_idx_o  output  IdxWidth  index of the input that currently owns the port, or of the last winner.

Behaviour:
- Reset (asynchronous, any cycle, including mid-packet):
  - state=IDLE, rr_ptr=0, owner=0.
  - valid_o=0, data_o=0, last_o=0, locked_o=0, grant_idx_o=0.
  - ready_o=0 while rst_i is high.
  - Any partial packet is abandoned; no flit is replayed.
- Output register: can_accept = !valid_o || ready_i.
  - Input flit handshake: valid_i[k] && ready_o[k].
  - On a handshake, data_o/last_o/valid_o load on the next edge, so latency is 1 cycle.
  - If ready_i && valid_o and no input handshake occurs, valid_o clears.
  - Back-to-back flits with no bubble when ready_i is held high.
- IDLE state:
  - sel = first k with valid_i[k]=1, searching from rr_ptr upward with wrap at NumInp-1 -> 0.
  - ready_o[sel] = can_accept; all other ready_o are 0.
  - With no valid_i set, all ready_o are 0.
  - Handshake with last_i[sel]=1: stay IDLE, rr_ptr = (sel+1) mod NumInp, grant_idx_o = sel.
  - Handshake with last_i[sel]=0: go to LOCKED, owner = sel, grant_idx_o = sel, locked_o=1.
  - No handshake: rr_ptr unchanged.
- LOCKED state:
  - ready_o[owner] = can_accept; all other ready_o are 0, even if owner is not valid (bubbles allowed).
  - Handshake with last_i[owner]=1: go to IDLE, rr_ptr = (owner+1) mod NumInp, locked_o=0.
  - Handshake with last_i[owner]=0: remain LOCKED.
- Single-flit packet (last=1 on first flit): never enters LOCKED.
- Wrap-around: owner = NumInp-1 finishing sets rr_ptr=0.
- Simultaneous events:
  - Output drain and new accept in the same cycle is allowed (pipelined).
  - Lock release and a new grant in the same cycle are NOT allowed: the new arbitration uses the updated rr_ptr in the next cycle, so there is one turnaround cycle at most at packet boundaries.
- Input protocol (upstream):
  - valid_i must not depend on ready_o.
  - Once raised, valid_i/data_i/last_i are held until accepted.
  - ready_o may depend combinationally on valid_i and ready_i.
- Assertions:
  - At most one ready_o bit high.
  - While valid_o && !ready_i, data_o/last_o are stable.
  - No handshake on a non-owner input while LOCKED.

Test Plan:
- Reset and idle: all valid_i=0, ready_i=1 after reset -> ready_o=4'b0000, valid_o=0, locked_o=0, grant_idx_o=0.
- Round-robin over single-flit packets: valid_i=4'b1111, last_i=4'b1111, ready_i=1 for 8 accepts -> grant order 0,1,2,3,0,1,2,3; each data_o appears 1 cycle after its handshake.
- Wormhole lock: input 2 sends a 3-flit packet (0xA0,0xA1,0xA2 with last on 0xA2) while input 0 is valid -> data_o sequence A0,A1,A2 uninterrupted; locked_o high until A2 is accepted; then input 0 is granted with rr_ptr=3 (input 3 has priority if valid).
- Backpressure: ready_i=0 for 5 cycles with valid_o=1 -> data_o/last_o stable; all ready_o=0 after the register fills; on ready_i=1 the flow resumes without loss or duplication.
- Owner bubble: locked on input 1, valid_i[1] drops for 3 cycles while input 3 is valid -> ready_o[3] stays 0 and the port stays locked until the last flit of input 1.
- Reset mid-packet: rst_i pulsed after flit 1 of a 4-flit packet on input 3 -> immediately valid_o=0, locked_o=0; after release, arbitration restarts from input 0.
